// File: rtl/axil_led_pkg.sv
// Shared constants for the AXI-Lite LED controller: register map, ID, LED modes and reset values.
package axil_led_pkg;

    // Register word indices (byte offset >> 2)
    localparam logic [5:0] REG_ID       = 6'h00;
    localparam logic [5:0] REG_SCRATCH  = 6'h01;
    localparam logic [5:0] REG_LED_MODE = 6'h02;
    localparam logic [5:0] REG_BLINK_MS = 6'h03;
    localparam logic [5:0] REG_PWM_DUTY = 6'h04;
    localparam logic [5:0] REG_LED_STAT = 6'h05;

    localparam logic [31:0] ID_VALUE = 32'h4C454430;  // "LED0"

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } led_mode_e;

    localparam logic [15:0] LED_MODE_RST = 16'h0002;  // LED0 blinks as a heartbeat
    localparam logic [15:0] BLINK_MS_RST = 16'd500;
    localparam logic [7:0]  PWM_DUTY_RST = 8'h40;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Offsets 0x00..0x14 are backed by registers; everything above decodes as a hole.
    function automatic logic is_mapped(input logic [5:0] idx);
        return idx <= REG_LED_STAT;
    endfunction

    // Byte-lane merge of a write into the current register contents.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_led_ctrl_tick.sv
// 1 ms prescaler: emits a single-cycle tick every DIV clock cycles.
module led_tick_gen #(
    parameter int DIV = 250000
) (
    input  logic axi_aclk,
    input  logic axi_aresetn,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Divider counter wraps at DIV-1 and fires the registered tick on the wrap
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (cnt_q == LAST);
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/axil_led_ctrl.sv
// AXI4-Lite register block driving 8 user LEDs with off/on/blink/PWM modes per LED.
module axil_led_ctrl
    import axil_led_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 250000000,
    parameter int ADDR_WIDTH     = 32,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [7:0]            LED
);

    localparam int TICK_DIV = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;

    logic        rst_done_q;
    logic        aw_held_q, w_held_q;
    logic [5:0]  aw_idx_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        bvalid_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;

    logic [31:0] scratch_q;
    logic [15:0] led_mode_q, blink_ms_q;
    logic [7:0]  pwm_duty_q;

    logic        tick_ms;
    logic [15:0] blink_cnt_q, blink_lim;
    logic        blink_q;
    logic [7:0]  pwm_cnt_q;
    logic        pwm_q;
    logic [7:0]  led_q, led_next;

    logic        aw_hs, w_hs, ar_hs, wr_commit;
    logic [5:0]  ar_idx;
    logic [31:0] rd_mux, wr_merged;
    logic        unused_ok;

    // Protection bits and address bits outside [7:2] carry no meaning here.
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

    assign s_axil_awready = rst_done_q && !aw_held_q && !bvalid_q;
    assign s_axil_wready  = rst_done_q && !w_held_q && !bvalid_q;
    assign s_axil_arready = rst_done_q && !rvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;

    assign aw_hs     = s_axil_awvalid && s_axil_awready;
    assign w_hs      = s_axil_wvalid && s_axil_wready;
    assign ar_hs     = s_axil_arvalid && s_axil_arready;
    assign wr_commit = aw_held_q && w_held_q;
    assign ar_idx    = s_axil_araddr[7:2];

    // Current contents of a register word as the host sees it.
    function automatic logic [31:0] reg_rd(input logic [5:0] idx);
        case (idx)
            REG_ID:       return ID_VALUE;
            REG_SCRATCH:  return scratch_q;
            REG_LED_MODE: return {16'h0, led_mode_q};
            REG_BLINK_MS: return {16'h0, blink_ms_q};
            REG_PWM_DUTY: return {24'h0, pwm_duty_q};
            REG_LED_STAT: return {24'h0, led_q};
            default:      return 32'h0;
        endcase
    endfunction

    // Read mux for the AR address and byte-lane merged value for the pending write
    always_comb begin
        rd_mux    = reg_rd(ar_idx);
        wr_merged = apply_wstrb(reg_rd(aw_idx_q), w_data_q, w_strb_q);
    end

    // Readies are held low until one edge after reset so they come from registered state
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) rst_done_q <= 1'b0;
        else              rst_done_q <= 1'b1;
    end

    // Write channel: independent AW/W holding registers, commit when both present, B response
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= s_axil_awaddr[7:2];
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end
            if (wr_commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= is_mapped(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && s_axil_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Writable registers; RO and unmapped words silently drop the write
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            scratch_q  <= '0;
            led_mode_q <= LED_MODE_RST;
            blink_ms_q <= BLINK_MS_RST;
            pwm_duty_q <= PWM_DUTY_RST;
        end else if (wr_commit) begin
            case (aw_idx_q)
                REG_SCRATCH:  scratch_q  <= wr_merged;
                REG_LED_MODE: led_mode_q <= wr_merged[15:0];
                REG_BLINK_MS: blink_ms_q <= wr_merged[15:0];
                REG_PWM_DUTY: pwm_duty_q <= wr_merged[7:0];
                default: ;
            endcase
        end
    end

    // Read channel: capture data on AR handshake, hold until rready
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
            rresp_q  <= is_mapped(ar_idx) ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    led_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .tick        (tick_ms)
    );

    // A zero half-period is treated as one tick.
    assign blink_lim = (blink_ms_q == 16'd0) ? 16'd1 : blink_ms_q;

    // Blink phase: count ms ticks, toggle at the half-period, restart on any BLINK_MS write
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (wr_commit && aw_idx_q == REG_BLINK_MS) begin
            blink_cnt_q <= '0;
        end else if (tick_ms) begin
            if (blink_cnt_q >= blink_lim - 16'd1) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 16'd1;
            end
        end
    end

    // Free-running 256-cycle PWM ramp
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) pwm_cnt_q <= '0;
        else              pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end

    assign pwm_q = (pwm_cnt_q < pwm_duty_q);

    // Per-LED source select from the 2-bit mode field
    always_comb begin
        led_next = '0;
        for (int i = 0; i < 8; i++) begin
            case (led_mode_e'(led_mode_q[2*i +: 2]))
                MODE_OFF:   led_next[i] = 1'b0;
                MODE_ON:    led_next[i] = 1'b1;
                MODE_BLINK: led_next[i] = blink_q;
                MODE_PWM:   led_next[i] = pwm_q;
                default:    led_next[i] = 1'b0;
            endcase
        end
    end

    // Registered LED drive so the pins are glitch-free
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) led_q <= '0;
        else              led_q <= led_next;
    end

    assign LED = led_q ^ {8{LED_ACTIVE_LOW}};

endmodule

// File: doc/axil_led_ctrl.md
# axil_led_ctrl

AXI4-Lite slave register block driving the board's 8 user LEDs with per-LED mode control (off / on / blink / PWM). Sits directly downstream of the XDMA `m_axil_*` master port in the top level, in the `axi_aclk` domain, and replaces the simple LED latch as the consumer of host BAR-mapped writes. Provides an ID register, a scratch register and an LED readback for host-side bring-up checks.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 250000000, `axi_aclk` frequency; sets the 1 ms tick divisor.
- `ADDR_WIDTH`, 32, AXI-Lite address width; only bits [7:2] are decoded.
- `LED_ACTIVE_LOW`, 0, 1 inverts `LED` at the pin.

Ports:
- `axi_aclk` in 1: the only clock.
- `axi_aresetn` in 1: reset, synchronous, active-low.
- `s_axil_awaddr` in ADDR_WIDTH; `s_axil_awprot` in 3 (ignored); `s_axil_awvalid` in 1; `s_axil_awready` out 1.
- `s_axil_wdata` in 32; `s_axil_wstrb` in 4; `s_axil_wvalid` in 1; `s_axil_wready` out 1.
- `s_axil_bresp` out 2; `s_axil_bvalid` out 1; `s_axil_bready` in 1.
- `s_axil_araddr` in ADDR_WIDTH; `s_axil_arprot` in 3 (ignored); `s_axil_arvalid` in 1; `s_axil_arready` out 1.
- `s_axil_rdata` out 32; `s_axil_rresp` out 2; `s_axil_rvalid` out 1; `s_axil_rready` in 1.
- `LED` out 8: LED drive.

## Operation
- Register map (byte offsets; decode is `addr[7:2]`):
  - 0x00 ID RO = 0x4C454430.
  - 0x04 SCRATCH RW, reset 0.
  - 0x08 LED_MODE RW [15:0], 2 bits per LED (LED i = bits [2i+1:2i]): 00 off, 01 on, 10 blink, 11 PWM. Reset 0x0002 (LED0 blinks as a heartbeat). Bits [31:16] read 0.
  - 0x0C BLINK_MS RW [15:0], blink half-period in ms. Reset 500. A value of 0 behaves as 1.
  - 0x10 PWM_DUTY RW [7:0]. Reset 0x40.
  - 0x14 LED_STAT RO [7:0] = logical LED state, before polarity inversion.
  - Offsets 0x18..0xFC: reads return 0, writes are ignored, and both respond SLVERR (2'b10). Mapped offsets respond OKAY.
- Writes honour `wstrb` per byte lane. Writes to RO registers are ignored and respond OKAY.
- Tick generator:
  - Produces a 1-cycle `tick_ms` pulse every `CLK_FREQ_HZ/1000` cycles.
  - The blink counter counts ticks and toggles `blink_q` when the count reaches `max(BLINK_MS,1)-1`, then clears.
  - A write to BLINK_MS clears the blink counter.
- PWM: an 8-bit counter free-runs on `axi_aclk` (period 256 cycles). `pwm_q = (pwm_cnt < PWM_DUTY)`, so duty 0 is always off and duty 255 is on 255 of 256 cycles.
- Per-LED output is registered: `led_q[i]` = mux(mode) of {0, 1, `blink_q`, `pwm_q`}. `LED = led_q ^ {8{LED_ACTIVE_LOW}}`.
- Write channel:
  - AW and W are accepted independently. Each is held in a one-entry holding register.
  - `awready` = !aw_held && !bvalid; `wready` = !w_held && !bvalid.
  - When both are held, the write commits on the next edge, both holds clear, and `bvalid` asserts with that edge. `bvalid` holds until `bready`.
- Read channel:
  - `arready` = !rvalid.
  - On accept, `rdata`/`rresp` are registered and `rvalid` asserts the following cycle. `rvalid` holds until `rready`.
- Same-edge read and write commit: the read returns the pre-write value.

## Timing
- Reset values (while `axi_aresetn`=0 and the first cycle after):
  - All ready outputs 0; `bvalid`/`rvalid` 0; `bresp`/`rresp` 0; `rdata` 0.
  - `led_q` 0, so `LED` = {8{LED_ACTIVE_LOW}}.
  - All counters 0; registers at their listed reset values.
- Readies rise on the first cycle after reset release, because they are derived from registered state.
- Write latency: AW and W in the same cycle → `bvalid` 2 cycles later. The register value is visible to a read accepted on the cycle `bvalid` rises.
- Read latency: `rvalid` 1 cycle after the AR handshake.
- `LED` changes 1 cycle after a mode or duty change takes effect internally.
- A reset asserted mid-transaction discards held AW/W and pending B/R responses. No response is ever issued for them.

## Structure
- Package `axil_led_pkg` holds:
  - register offset localparams;
  - the `ID_VALUE` constant;
  - the 2-bit mode encodings (`MODE_OFF`, `MODE_ON`, `MODE_BLINK`, `MODE_PWM`);
  - reset values for LED_MODE, BLINK_MS and PWM_DUTY.
- Sub-module `led_tick_gen` (parameter `DIV`; ports `axi_aclk`, `axi_aresetn`, `tick`) is the 1 ms prescaler. Everything else lives in `axil_led_ctrl`.

## Test plan
- Reset release, read 0x00, 0x08, 0x0C, 0x10 → 0x4C454430, 0x00000002, 0x000001F4, 0x00000040, all OKAY.
- Write 0x04 = 0xDEADBEEF with wstrb 0b0101, then read → 0x00AD00EF. Run once with AW one cycle before W and once with W one cycle before AW; both give the same result.
- LED_MODE = 0x5555 → `LED` = 0xFF. LED_MODE = 0x0000 → `LED` = 0x00. LED_STAT matches in both cases.
- Use `CLK_FREQ_HZ`=1000 (tick every cycle), BLINK_MS = 3, LED_MODE = 0x0002 → LED0 toggles every 3 cycles. BLINK_MS = 0 → LED0 toggles every cycle.
- LED_MODE = 0xFFFF, PWM_DUTY = 0x40 → each LED is high exactly 64 of 256 cycles. Duty 0 → constant low. Duty 0xFF → 255/256.
- Read and write 0x40 → SLVERR, rdata 0. Hold `bready` low for 5 cycles → `awready`/`wready` stay 0 and `bvalid` holds. Assert reset mid-hold → `bvalid` 0 and no response is issued.
